branch_predictor_bimodal: RTL and testbench
===========================================

// Module: branch_predictor_bimodal
// PURPOSE
//  Parametrised dynamic branch predictor for the fetch stage. Replaces static BTFNT with a
//  PC-indexed table of 2-bit saturating counters; PRED_MODE=0 keeps BTFNT.
//  Emits the fetch offset combinationally and pipelines the alternate (not-predicted) PC
//  to the resolve stage, so a mispredict redirects in one cycle.
// PARAMETERS
//  PC_W          17     PC / absolute target width
//  OFFSET_W      17     signed branch offset width (two's complement)
//  IDX_W         6      counter-table index bits; depth = 2**IDX_W
//  RECOVER_DEPTH 2      pipeline stages from fetch to resolve (>=1)
//  PRED_MODE     1      0 = static BTFNT, 1 = bimodal counters
//  CTR_INIT      2'b01  counter reset value (01 = weakly not-taken)
// PORTS
//  clk               in   1         clock, all state on rising edge
//  rst_n             in   1         asynchronous reset, active low
//  stall             in   1         hold recovery pipeline
//  halted            in   1         freeze all state, including counter updates
//  fetch_pc          in   PC_W      PC of instruction in fetch
//  opcode            in   5         fetch opcode: BT=23, BF=24, JAL=25
//  branch_target     in   OFFSET_W  signed offset from fetch_pc
//  predicted_offset  out  OFFSET_W  offset added to fetch_pc for next fetch
//  predicted_taken   out  1         1 if a taken prediction was made
//  resolve_valid     in   1         conditional branch resolved this cycle
//  resolve_pc        in   PC_W      PC of the resolved branch
//  resolve_taken     in   1         actual direction
//  guess_wrong       in   1         resolve stage reports mispredict
//  recover_pc        out  PC_W      alternate PC of the instruction now at resolve
//  recover_valid     out  1         recover_pc belongs to a conditional branch
// BEHAVIOUR
//  Reset (rst_n=0, async): all counters = CTR_INIT, recovery pipeline cleared,
//   recover_pc=0, recover_valid=0. Combinational outputs are unaffected by reset.
//  Prediction (combinational, same cycle):
//   - BT/BF, PRED_MODE=0: taken iff $signed(branch_target)<0.
//   - BT/BF, PRED_MODE=1: taken iff ctr[fetch_pc[IDX_W-1:0]][1]==1.
//   - JAL: always taken. Other opcodes: not taken.
//   - Taken: predicted_offset=branch_target, predicted_taken=1.
//     Otherwise predicted_offset=1, predicted_taken=0.
//  Alternate PC at fetch, PC_W modular add, offset sign-extended/truncated to PC_W:
//   - Predicted taken: fetch_pc+1. Predicted not-taken: fetch_pc+branch_target.
//   - Entry valid only for BT/BF; JAL and non-branches push valid=0.
//  Recovery pipeline: RECOVER_DEPTH-entry shift register of {valid, alt_pc}.
//   - Advances when !stall && !halted. Tail drives recover_pc/recover_valid, so
//     latency fetch->recover = RECOVER_DEPTH advancing cycles.
//   - guess_wrong && advancing: all entries behind the tail are wrong-path;
//     clear their valid bits. The tail still shifts out normally and the new head
//     entry is written.
//   - stall or halted: pipeline holds, outputs hold.
//  Counter update, when resolve_valid && !halted, independent of stall:
//   - Index resolve_pc[IDX_W-1:0]; taken: ctr=min(ctr+1,3); not taken: ctr=max(ctr-1,0).
//   - Saturates, never wraps. PRED_MODE=0 still updates counters; they are not used.
//   - Same-index read and write in one cycle: fetch reads the pre-update value (no bypass).
//  Aliasing: PCs equal mod 2**IDX_W share a counter; this is intended.
//  Reset mid-operation clears in-flight recovery entries; the next fetch predicts from CTR_INIT.
// TESTING
//  1 Reset, BT @pc=0x10 target=+8 -> predicted_offset=1, taken=0; 2 cycles later
//    recover_pc=0x18, recover_valid=1.
//  2 Three resolve_valid taken @pc=0x10, then fetch BT @0x10 target=-4 -> taken=1,
//    offset=0x1FFFC, recover_pc 2 cycles later = 0x11.
//  3 Saturation: 5 taken resolves, then 1 not-taken -> still predicts taken; 3 more
//    not-taken -> ctr=0, predicts not-taken.
//  4 JAL target=+32 -> offset=32, taken=1, recover_valid=0 at resolve.
//  5 BT fetch, next cycle guess_wrong=1 -> that younger entry reaches tail with
//    recover_valid=0.
//  6 stall held 3 cycles mid-flight -> recover_pc unchanged; also pulse rst_n low
//    mid-pipeline -> recover_valid=0 immediately and counters read CTR_INIT.

Source files
------------

// File: rtl/branch_predictor_bimodal_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_bimodal_if
// Bundles the fetch, resolve and recovery signals of the bimodal branch
// predictor so the fetch/resolve logic and the predictor share one port.
//
//   stall            fetch->predictor   hold recovery pipeline
//   halted           fetch->predictor   freeze all predictor state
//   fetch_pc         fetch->predictor   PC of instruction in fetch
//   opcode           fetch->predictor   fetch opcode (BT=23, BF=24, JAL=25)
//   branch_target    fetch->predictor   signed offset from fetch_pc
//   predicted_offset predictor->fetch   offset for next fetch
//   predicted_taken  predictor->fetch   taken prediction made
//   resolve_valid    resolve->predictor conditional branch resolved
//   resolve_pc       resolve->predictor PC of the resolved branch
//   resolve_taken    resolve->predictor actual direction
//   guess_wrong      resolve->predictor mispredict reported
//   recover_pc       predictor->resolve alternate PC of the resolving branch
//   recover_valid    predictor->resolve recover_pc belongs to a cond. branch
//
// master: the pipeline side driving fetch/resolve information.
// slave : the predictor itself.
// ---------------------------------------------------------------------------
interface branch_predictor_bimodal_if #(
  parameter int PC_W     = 17,
  parameter int OFFSET_W = 17
);
  logic                       stall;
  logic                       halted;
  logic [PC_W-1:0]            fetch_pc;
  logic [4:0]                 opcode;
  logic signed [OFFSET_W-1:0] branch_target;
  logic signed [OFFSET_W-1:0] predicted_offset;
  logic                       predicted_taken;
  logic                       resolve_valid;
  logic [PC_W-1:0]            resolve_pc;
  logic                       resolve_taken;
  logic                       guess_wrong;
  logic [PC_W-1:0]            recover_pc;
  logic                       recover_valid;

  modport master (
    output stall, halted, fetch_pc, opcode, branch_target,
    output resolve_valid, resolve_pc, resolve_taken, guess_wrong,
    input  predicted_offset, predicted_taken, recover_pc, recover_valid
  );

  modport slave (
    input  stall, halted, fetch_pc, opcode, branch_target,
    input  resolve_valid, resolve_pc, resolve_taken, guess_wrong,
    output predicted_offset, predicted_taken, recover_pc, recover_valid
  );
endinterface

// File: rtl/branch_predictor_bimodal.sv
// ---------------------------------------------------------------------------
// branch_predictor_bimodal
// Dynamic branch predictor for the fetch stage. A PC-indexed table of 2-bit
// saturating counters predicts BT/BF direction (PRED_MODE=1); PRED_MODE=0
// falls back to static backward-taken/forward-not-taken. The fetch offset is
// produced combinationally; the alternate (not-predicted) PC travels down a
// RECOVER_DEPTH-entry shift register so the resolve stage can redirect in
// one cycle on a mispredict.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset (counters -> CTR_INIT, recovery
//          pipeline cleared)
//   bus    branch_predictor_bimodal_if.slave, see the interface file for the
//          per-signal description
// ---------------------------------------------------------------------------
module branch_predictor_bimodal #(
  parameter int         PC_W          = 17,
  parameter int         OFFSET_W      = 17,
  parameter int         IDX_W         = 6,
  parameter int         RECOVER_DEPTH = 2,
  parameter int         PRED_MODE     = 1,
  parameter logic [1:0] CTR_INIT      = 2'b01
) (
  input  logic                      clk,
  input  logic                      rst_n,
  branch_predictor_bimodal_if.slave bus
);

  localparam int         DEPTH  = 1 << IDX_W;
  localparam logic [4:0] OP_BT  = 5'd23;
  localparam logic [4:0] OP_BF  = 5'd24;
  localparam logic [4:0] OP_JAL = 5'd25;

  localparam logic signed [OFFSET_W-1:0] OFF_ONE = {{(OFFSET_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]            PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Offset sign-extended to cover any PC_W, then truncated to PC_W so the
  // alternate-PC add is modular in the PC width.
  function automatic logic [PC_W-1:0] off_to_pc(input logic signed [OFFSET_W-1:0] off);
    logic [PC_W+OFFSET_W-1:0] wide;
    wide = {{PC_W{off[OFFSET_W-1]}}, off};
    return wide[PC_W-1:0];
  endfunction

  logic [1:0]                ctr_q [DEPTH];
  logic [1:0]                ctr_d [DEPTH];
  logic [PC_W-1:0]           rec_pc_q [RECOVER_DEPTH];
  logic [PC_W-1:0]           rec_pc_d [RECOVER_DEPTH];
  logic [RECOVER_DEPTH-1:0]  rec_vld_q;
  logic [RECOVER_DEPTH-1:0]  rec_vld_d;

  logic [IDX_W-1:0]          fetch_idx;
  logic [IDX_W-1:0]          resolve_idx;
  logic [1:0]                ctr_rd;
  logic                      is_cond;
  logic                      is_jal;
  logic                      cond_dir;
  logic                      pred_taken;
  logic [PC_W-1:0]           alt_pc;
  logic                      advance;
  logic                      ctr_upd;
  logic                      unused_resolve_hi;

  // ---- fetch stage: combinational prediction --------------------------------
  assign fetch_idx   = bus.fetch_pc[IDX_W-1:0];
  assign resolve_idx = bus.resolve_pc[IDX_W-1:0];
  assign unused_resolve_hi = ^bus.resolve_pc;

  // Fetch always sees the registered counter, so a same-cycle update to the
  // same index is not visible until the next cycle.
  assign ctr_rd  = ctr_q[fetch_idx];
  assign is_cond = (bus.opcode == OP_BT) || (bus.opcode == OP_BF);
  assign is_jal  = (bus.opcode == OP_JAL);

  always_comb begin
    cond_dir = 1'b0;
    if (PRED_MODE != 0) begin
      cond_dir = ctr_rd[1];
    end else begin
      cond_dir = bus.branch_target[OFFSET_W-1];
    end
  end

  assign pred_taken = is_jal || (is_cond && cond_dir);

  assign bus.predicted_taken  = pred_taken;
  assign bus.predicted_offset = pred_taken ? bus.branch_target : OFF_ONE;

  // The alternate path is whichever way the prediction did not go.
  assign alt_pc = pred_taken ? (bus.fetch_pc + PC_ONE)
                             : (bus.fetch_pc + off_to_pc(bus.branch_target));

  // ---- recovery pipeline: fetch -> resolve ----------------------------------
  assign advance = !bus.stall && !bus.halted;

  // Index 0 is the head (youngest), RECOVER_DEPTH-1 the tail at resolve. On a
  // mispredict everything still behind the tail is wrong-path, so its valid
  // bit is dropped as it shifts; the new head entry is written regardless.
  always_comb begin
    rec_pc_d  = rec_pc_q;
    rec_vld_d = rec_vld_q;
    if (advance) begin
      rec_pc_d[0]  = alt_pc;
      rec_vld_d[0] = is_cond;
      for (int i = 1; i < RECOVER_DEPTH; i++) begin
        rec_pc_d[i]  = rec_pc_q[i-1];
        rec_vld_d[i] = rec_vld_q[i-1] & ~bus.guess_wrong;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RECOVER_DEPTH; i++) begin
        rec_pc_q[i] <= '0;
      end
      rec_vld_q <= '0;
    end else begin
      rec_pc_q  <= rec_pc_d;
      rec_vld_q <= rec_vld_d;
    end
  end

  assign bus.recover_pc    = rec_pc_q[RECOVER_DEPTH-1];
  assign bus.recover_valid = rec_vld_q[RECOVER_DEPTH-1];

  // ---- resolve stage: counter training --------------------------------------
  // Training ignores stall: a resolved branch is architectural fact even when
  // fetch is held. Only halted freezes the table.
  assign ctr_upd = bus.resolve_valid && !bus.halted;

  always_comb begin
    ctr_d = ctr_q;
    if (ctr_upd) begin
      ctr_d[resolve_idx] = bus.resolve_taken ? sat_inc(ctr_q[resolve_idx])
                                             : sat_dec(ctr_q[resolve_idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
module tb_branch_predictor_bimodal;

  localparam int PC_W      = 17;
  localparam int OFFSET_W  = 17;
  localparam int IDX_W     = 6;
  localparam int RDEPTH    = 2;
  localparam int PRED_MODE = 1;
  localparam int CTR_INIT  = 1;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int PMASK     = (1 << PC_W) - 1;
  localparam int OMASK     = (1 << OFFSET_W) - 1;
  localparam int OP_BT = 23, OP_BF = 24, OP_JAL = 25;

  logic clk;
  logic rst_n;
  bit   check_en = 0;
  int   nvec  = 0;
  int   nfail = 0;

  branch_predictor_bimodal_if #(.PC_W(PC_W), .OFFSET_W(OFFSET_W)) bus ();

  branch_predictor_bimodal #(
    .PC_W(PC_W), .OFFSET_W(OFFSET_W), .IDX_W(IDX_W), .RECOVER_DEPTH(RDEPTH),
    .PRED_MODE(PRED_MODE), .CTR_INIT(2'(CTR_INIT))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  int mcnt [DEPTH];
  bit mq_v [$];
  int mq_pc [$];

  function automatic void mpred(input int pc, input int op, input int traw,
                                output bit tk, output int off, output int alt, output bit v);
    int ts;
    bit dir;
    ts  = (traw >= (1 << (OFFSET_W-1))) ? traw - (1 << OFFSET_W) : traw;
    v   = (op == OP_BT) || (op == OP_BF);
    if (PRED_MODE != 0) dir = (mcnt[pc % DEPTH] >= 2);
    else                dir = (ts < 0);
    tk  = (op == OP_JAL) || (v && dir);
    off = tk ? (ts & OMASK) : 1;
    alt = tk ? ((pc + 1) & PMASK) : ((pc + ts) & PMASK);
  endfunction

  task automatic model_reset();
    foreach (mcnt[i]) mcnt[i] = CTR_INIT;
    mq_v.delete();
    mq_pc.delete();
    for (int i = 0; i < RDEPTH; i++) begin
      mq_v.push_back(1'b0);
      mq_pc.push_back(0);
    end
  endtask

  task automatic model_update();
    bit tk, v;
    int off, alt, ix;
    if (!rst_n || bus.halted) return;
    mpred(int'(bus.fetch_pc), int'(bus.opcode), int'($unsigned(bus.branch_target)), tk, off, alt, v);
    if (!bus.stall) begin
      void'(mq_v.pop_front());
      void'(mq_pc.pop_front());
      if (bus.guess_wrong) foreach (mq_v[i]) mq_v[i] = 1'b0;
      mq_v.push_back(v);
      mq_pc.push_back(alt);
    end
    if (bus.resolve_valid) begin
      ix = int'(bus.resolve_pc) % DEPTH;
      if (bus.resolve_taken) mcnt[ix] = (mcnt[ix] < 3) ? mcnt[ix] + 1 : 3;
      else                   mcnt[ix] = (mcnt[ix] > 0) ? mcnt[ix] - 1 : 0;
    end
  endtask

  task automatic cmp(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : compare_proc
    bit tk, v;
    int off, alt;
    #2;
    if (check_en) begin
      mpred(int'(bus.fetch_pc), int'(bus.opcode), int'($unsigned(bus.branch_target)), tk, off, alt, v);
      cmp("model_pred_taken", bus.predicted_taken, tk);
      cmp("model_pred_offset", $unsigned(bus.predicted_offset), off);
      cmp("model_recover_valid", bus.recover_valid, mq_v[0]);
      cmp("model_recover_pc", bus.recover_pc, mq_pc[0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_fetch(input int pc, input int op, input int tgt);
    bus.fetch_pc      = PC_W'(pc);
    bus.opcode        = 5'(op);
    bus.branch_target = OFFSET_W'(tgt);
  endtask

  task automatic set_res(input bit v, input int pc, input bit t);
    bus.resolve_valid = v;
    bus.resolve_pc    = PC_W'(pc);
    bus.resolve_taken = t;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic nop();
    set_fetch(32'h20, 0, 0);
  endtask

  int ops  [6] = '{OP_BT, OP_BF, OP_JAL, 3, OP_BT, OP_BF};
  int tgts [8] = '{5, -3, 12, -40, 1, 0, 100, -1};

  initial begin
    rst_n = 0;
    bus.stall = 0;
    bus.halted = 0;
    bus.guess_wrong = 0;
    set_fetch(0, 0, 0);
    set_res(0, 0, 0);
    model_reset();

    @(negedge clk);
    check_en = 1;
    #3;
    cmp("reset_recover_valid", bus.recover_valid, 0);
    cmp("reset_recover_pc", bus.recover_pc, 0);
    tick();
    rst_n = 1;

    // Forward BT from reset: counter weakly not-taken
    set_fetch(32'h10, OP_BT, 8);
    #3;
    cmp("t1_offset", $unsigned(bus.predicted_offset), 1);
    cmp("t1_taken", bus.predicted_taken, 0);
    tick();
    nop();
    tick();
    #3;
    cmp("t1_recover_pc", bus.recover_pc, 32'h18);
    cmp("t1_recover_valid", bus.recover_valid, 1);

    // Train taken at 0x10, then backward BT
    nop();
    set_res(1, 32'h10, 1);
    repeat (3) tick();
    set_res(0, 0, 0);
    set_fetch(32'h10, OP_BT, -4);
    #3;
    cmp("t2_taken", bus.predicted_taken, 1);
    cmp("t2_offset", $unsigned(bus.predicted_offset), 32'h1FFFC);
    tick();
    nop();
    tick();
    #3;
    cmp("t2_recover_pc", bus.recover_pc, 32'h11);
    cmp("t2_recover_valid", bus.recover_valid, 1);

    // Saturation
    nop();
    set_res(1, 32'h10, 1);
    repeat (5) tick();
    set_res(1, 32'h10, 0);
    tick();
    set_res(0, 0, 0);
    set_fetch(32'h10, OP_BT, 4);
    #3;
    cmp("t3_sat_still_taken", bus.predicted_taken, 1);
    tick();
    nop();
    set_res(1, 32'h10, 0);
    repeat (3) tick();
    set_res(0, 0, 0);
    set_fetch(32'h10, OP_BT, 4);
    #3;
    cmp("t3_floor_taken", bus.predicted_taken, 0);
    cmp("t3_floor_offset", $unsigned(bus.predicted_offset), 1);
    tick();

    // JAL
    set_fetch(32'h30, OP_JAL, 32);
    #3;
    cmp("t4_offset", $unsigned(bus.predicted_offset), 32);
    cmp("t4_taken", bus.predicted_taken, 1);
    tick();
    nop();
    tick();
    #3;
    cmp("t4_recover_valid", bus.recover_valid, 0);
    cmp("t4_recover_pc", bus.recover_pc, 32'h31);

    // Mispredict squashes the younger entry
    set_fetch(32'h40, OP_BT, 5);
    tick();
    nop();
    bus.guess_wrong = 1;
    tick();
    bus.guess_wrong = 0;
    #3;
    cmp("t5_squash_valid", bus.recover_valid, 0);
    cmp("t5_squash_pc", bus.recover_pc, 32'h45);

    // Stall holds the recovery pipeline
    set_fetch(32'h50, OP_BT, 3);
    tick();
    nop();
    tick();
    #3;
    cmp("t6_pre_stall_pc", bus.recover_pc, 32'h53);
    bus.stall = 1;
    set_fetch(32'h60, OP_BT, 7);
    repeat (3) begin
      tick();
      #3;
      cmp("t6_stall_pc", bus.recover_pc, 32'h53);
      cmp("t6_stall_valid", bus.recover_valid, 1);
    end

    // Counters train during stall
    set_res(1, 32'h20, 1);
    repeat (2) tick();
    set_res(0, 0, 0);
    bus.stall = 0;
    set_fetch(32'h20, OP_BF, 4);
    #3;
    cmp("t6_stall_trains", bus.predicted_taken, 1);
    tick();

    // Halted freezes counters
    nop();
    bus.halted = 1;
    set_res(1, 32'h10, 1);
    repeat (2) tick();
    bus.halted = 0;
    set_res(0, 0, 0);
    set_fetch(32'h10, OP_BT, 4);
    #3;
    cmp("t6_halt_no_train", bus.predicted_taken, 0);
    tick();

    // Reset mid-flight
    set_fetch(32'h20, OP_BT, 6);
    repeat (2) tick();
    #3;
    cmp("t6_pre_reset_valid", bus.recover_valid, 1);
    rst_n = 0;
    model_reset();
    #1;
    cmp("t6_reset_valid", bus.recover_valid, 0);
    cmp("t6_reset_ctr_init", bus.predicted_taken, 0);
    tick();
    rst_n = 1;

    // Mixed directed pattern
    for (int i = 0; i < 40; i++) begin
      set_fetch((i * 37) & PMASK, ops[i % 6], tgts[i % 8]);
      set_res(i % 2 == 1, (i * 5) & 63, (i % 3) != 0);
      bus.guess_wrong = (i % 7 == 3);
      bus.stall       = (i % 5 == 4);
      tick();
    end
    bus.stall = 0;
    bus.guess_wrong = 0;
    set_res(0, 0, 0);
    tick();

    check_en = 0;
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
